// File: rtl/jpeg_block_stream_ctrl.sv
// Valid/ready wrapper around the free-running JPEG block datapath: tags accepted blocks
// through the pipeline latency and buffers emerging coefficients in a credit-protected FIFO.
module jpeg_block_stream_ctrl #(
   parameter int COEF_W     = 32,
   parameter int NUM_CH     = 3,
   parameter int PIPE_LAT   = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int IDX_W      = 16,
   localparam int DATA_W    = NUM_CH * 64 * COEF_W,
   localparam int INF_W     = $clog2(PIPE_LAT + 1)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   input  logic              in_last_i,
   output logic              in_ready_o,
   output logic              pipe_start_o,
   input  logic [DATA_W-1:0] pipe_coefs_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_coefs_o,
   output logic              out_last_o,
   output logic [IDX_W-1:0]  out_block_idx_o,
   output logic [INF_W-1:0]  inflight_o,
   output logic              frame_done_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic             vld;
      logic             last;
      logic [IDX_W-1:0] idx;
   } tag_t;

   tag_t              tag_q [PIPE_LAT];
   logic [INF_W-1:0]  inflight_q, inflight_d;
   logic [IDX_W-1:0]  idx_cnt_q, idx_cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              frame_done_q;

   logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
   logic              mem_last_q [FIFO_DEPTH];
   logic [IDX_W-1:0]  mem_idx_q  [FIFO_DEPTH];

   logic accept, push, pop;

   // Every accepted block already owns a FIFO slot, so a capture can never find the FIFO full.
   assign in_ready_o   = !reset_i && ((32'(inflight_q) + 32'(count_q)) < FIFO_DEPTH);
   assign accept       = in_valid_i && in_ready_o;
   assign pipe_start_o = accept;
   assign push         = tag_q[PIPE_LAT-1].vld;
   assign pop          = out_valid_o && out_ready_i;

   assign out_valid_o     = (count_q != '0);
   assign out_coefs_o     = out_valid_o ? mem_data_q[rd_ptr_q] : '0;
   assign out_last_o      = out_valid_o ? mem_last_q[rd_ptr_q] : 1'b0;
   assign out_block_idx_o = out_valid_o ? mem_idx_q[rd_ptr_q]  : '0;
   assign inflight_o      = inflight_q;
   assign frame_done_o    = frame_done_q;

   always_comb begin
      inflight_d = inflight_q;
      if (accept && !push)
         inflight_d = inflight_q + INF_W'(1);
      else if (!accept && push)
         inflight_d = inflight_q - INF_W'(1);

      count_d = count_q;
      if (push && !pop)
         count_d = count_q + CNT_W'(1);
      else if (!push && pop)
         count_d = count_q - CNT_W'(1);

      idx_cnt_d = idx_cnt_q;
      if (accept)
         idx_cnt_d = in_last_i ? '0 : idx_cnt_q + IDX_W'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < PIPE_LAT; i++)
            tag_q[i] <= '0;
         inflight_q   <= '0;
         idx_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         tag_q[0] <= '{vld: accept, last: in_last_i, idx: idx_cnt_q};
         for (int i = 1; i < PIPE_LAT; i++)
            tag_q[i] <= tag_q[i-1];
         inflight_q   <= inflight_d;
         idx_cnt_q    <= idx_cnt_d;
         count_q      <= count_d;
         frame_done_q <= pop && out_last_o;
         if (push)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Storage is left unreset so it maps onto RAM; out_* are masked while empty instead.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= pipe_coefs_i;
         mem_last_q[wr_ptr_q] <= tag_q[PIPE_LAT-1].last;
         mem_idx_q[wr_ptr_q]  <= tag_q[PIPE_LAT-1].idx;
      end
   end

   fifo_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(push && count_q == CNT_W'(FIFO_DEPTH)));

endmodule
